// File: rtl/rv_mem_responder.sv
// Memory-side responder for the RV32I core: serialises fetch and data accesses onto one
// shared single-port word memory and holds the core stalled until both complete.
module rv_mem_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_f,
    input  logic [31:0]       alu_result_m,
    input  logic [31:0]       write_data_m,
    input  logic              mem_write_m,
    output logic [31:0]       inst_f,
    output logic [31:0]       read_data_m,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIssueF, StWaitF, StIssueD, StWaitD, StRun} state_e;

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    function automatic logic in_range(input logic [31:0] byte_addr);
        return (byte_addr >> (ADDR_W + 2)) == 32'd0;
    endfunction

    // An ack in the last allowed cycle counts as a normal completion.
    assign timed_out = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIssueF;
            stall       <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            inst_f      <= NOP_INST;
            read_data_m <= '0;
            bus_err     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                StIssueF: begin
                    if (in_range(pc_f)) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_f[ADDR_W+1:2];
                        state    <= StWaitF;
                    end else begin
                        inst_f  <= NOP_INST;
                        bus_err <= 1'b1;
                        state   <= StIssueD;
                    end
                end
                StWaitF: begin
                    if (mem_ack) begin
                        inst_f   <= mem_rdata;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= StIssueD;
                    end else if (timed_out) begin
                        inst_f   <= NOP_INST;
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= StIssueD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StIssueD: begin
                    if (in_range(alu_result_m)) begin
                        mem_req  <= 1'b1;
                        mem_we   <= mem_write_m;
                        mem_addr <= alu_result_m[ADDR_W+1:2];
                        if (mem_write_m) begin
                            mem_wdata <= write_data_m;
                        end
                        state <= StWaitD;
                    end else begin
                        // Out-of-range stores are dropped; loads return zero.
                        if (!mem_write_m) begin
                            read_data_m <= '0;
                        end
                        bus_err <= 1'b1;
                        stall   <= 1'b0;
                        state   <= StRun;
                    end
                end
                StWaitD: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            read_data_m <= mem_rdata;
                        end
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        stall    <= 1'b0;
                        state    <= StRun;
                    end else if (timed_out) begin
                        if (!mem_we) begin
                            read_data_m <= '0;
                        end
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                        stall    <= 1'b0;
                        state    <= StRun;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StRun: begin
                    stall <= 1'b1;
                    state <= StIssueF;
                end
                default: begin
                    stall <= 1'b1;
                    state <= StIssueF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_responder.sv
// Bench for rv_mem_responder: a per-step model builds the expected cycle-by-cycle schedule,
// a single negedge process compares the DUT against it.
module tb_rv_mem_responder;

    localparam int          AW  = 10;
    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk, reset;
    logic [31:0]   pc_f, alu_result_m, write_data_m;
    logic          mem_write_m;
    logic [31:0]   inst_f, read_data_m;
    logic          stall, mem_req, mem_we, mem_ack, bus_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    rv_mem_responder #(.ADDR_W(AW), .TIMEOUT(TO), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .mem_write_m(mem_write_m), .inst_f(inst_f),
        .read_data_m(read_data_m), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: acks the n-th request of a step after dly_a / dly_b idle wait cycles.
    logic [31:0] mem [0:(1<<AW)-1];
    int          wcnt, req_n, dly_a, dly_b;
    bit          stray_ack;

    function automatic logic [31:0] fill(input int i);
        return 32'h1000_0000 + 32'(i * 3);
    endfunction

    assign mem_ack   = stray_ack | (mem_req && wcnt == (req_n == 0 ? dly_a : dly_b));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (reset) begin
            wcnt  <= 0;
            req_n <= 0;
            for (int i = 0; i < (1 << AW); i++) mem[i] <= fill(i);
            mem[0]  <= 32'h0050_0093;
            mem[16] <= 32'hDEAD_BEEF;
        end else if (!stall) begin
            wcnt  <= 0;
            req_n <= 0;
        end else if (mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            req_n <= req_n + 1;
            wcnt  <= 0;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else if (wcnt != 0) begin
            req_n <= req_n + 1;
            wcnt  <= 0;
        end
    end

    typedef struct packed {
        bit            stall, req, we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        bit            chk_data;
        logic [31:0]   inst, rd;
        bit            err, has_lit;
        logic [31:0]   lit_inst, lit_rd;
        bit            lit_err, chk_mem;
        logic [AW-1:0] mem_idx;
        logic [31:0]   mem_val;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("stall", 32'(stall), 32'(cur.stall));
            check("mem_req", 32'(mem_req), 32'(cur.req));
            if (cur.req) begin
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
            end
            if (cur.chk_data) begin
                check("inst_f", inst_f, cur.inst);
                check("read_data_m", read_data_m, cur.rd);
                check("bus_err", 32'(bus_err), 32'(cur.err));
            end
            if (cur.has_lit) begin
                check("lit_inst_f", inst_f, cur.lit_inst);
                check("lit_read_data_m", read_data_m, cur.lit_rd);
                check("lit_bus_err", 32'(bus_err), 32'(cur.lit_err));
            end
            if (cur.chk_mem) check("mem_word", mem[cur.mem_idx], cur.mem_val);
        end
    end

    // Model state: what the core-facing outputs must hold after each step.
    logic [31:0] m_inst, m_rd;
    logic        m_err;

    function automatic exp_t mk(input bit s, input bit r, input bit w, input logic [AW-1:0] a,
                                input logic [31:0] wd);
        exp_t e;
        e = '0;
        e.stall = s; e.req = r; e.we = w; e.addr = a; e.wdata = wd;
        return e;
    endfunction

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL drain_bound: got %0d pending want 0", exp_q.size());
                $fatal(1, "bench stuck");
            end
        end
        #1;
    endtask

    task automatic run_step(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                            input logic we, input int df, input int dd, input bit stray,
                            input logic [31:0] li, input logic [31:0] lr, input logic le);
        bit   f_ok  = (pc >> (AW + 2)) == 0;
        bit   d_ok  = (alu >> (AW + 2)) == 0;
        bit   f_ack = df < TO;
        bit   d_ack = dd < TO;
        exp_t e;
        pc_f = pc; alu_result_m = alu; write_data_m = wd; mem_write_m = we;
        dly_a = f_ok ? df : dd;
        dly_b = dd;
        stray_ack = stray;
        e = mk(1, 0, 0, '0, '0);
        e.chk_data = 1; e.inst = m_inst; e.rd = m_rd; e.err = m_err;
        exp_q.push_back(e);
        m_inst = (f_ok && f_ack) ? mem[pc[AW+1:2]] : NOP;
        if (!f_ok || !f_ack) m_err = 1;
        if (f_ok) repeat (f_ack ? df + 1 : TO) exp_q.push_back(mk(1, 1, 0, pc[AW+1:2], '0));
        exp_q.push_back(mk(1, 0, 0, '0, '0));
        if (d_ok) repeat (d_ack ? dd + 1 : TO) exp_q.push_back(mk(1, 1, we, alu[AW+1:2], wd));
        if (!d_ok || !d_ack) begin
            m_err = 1;
            if (!we) m_rd = 0;
        end else if (!we) begin
            m_rd = mem[alu[AW+1:2]];
        end
        e = mk(0, 0, 0, '0, '0);
        e.chk_data = 1; e.inst = m_inst; e.rd = m_rd; e.err = m_err;
        e.has_lit = 1; e.lit_inst = li; e.lit_rd = lr; e.lit_err = le;
        e.chk_mem = we && d_ok && d_ack; e.mem_idx = alu[AW+1:2]; e.mem_val = wd;
        exp_q.push_back(e);
        if (stray) begin
            @(posedge clk);
            #1 stray_ack = 0;
        end
        wait_drain();
    endtask

    initial begin
        exp_t e;
        reset = 1; pc_f = 0; alu_result_m = 0; write_data_m = 0; mem_write_m = 0;
        dly_a = 0; dly_b = 0; stray_ack = 0;
        m_inst = NOP; m_rd = 0; m_err = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        run_step(32'h0,  32'h40, 0, 0, 0, 0, 0, 32'h0050_0093, 32'hDEAD_BEEF, 0);
        run_step(32'h4,  32'd100, 32'd25, 1, 0, 0, 0, 32'h1000_0003, 32'hDEAD_BEEF, 0);
        run_step(32'h8,  32'h48, 0, 0, 5, 5, 0, 32'h1000_0006, 32'h1000_0036, 0);
        run_step(32'hC,  32'h4C, 0, 0, 15, 0, 0, 32'h1000_0009, 32'h1000_0039, 0);
        run_step(32'h10, 32'h40, 0, 0, 99, 0, 0, NOP, 32'hDEAD_BEEF, 1);
        run_step(32'h1000, 32'h44, 0, 0, 0, 0, 0, NOP, 32'h1000_0033, 1);
        run_step(32'h14, 32'hFFFF_0000, 0, 0, 0, 0, 0, 32'h1000_000F, 32'h0, 1);
        run_step(32'h18, 32'h40, 0, 0, 0, 99, 0, 32'h1000_0012, 32'h0, 1);
        run_step(32'h1C, 32'h8000_0000, 32'd55, 1, 0, 0, 0, 32'h1000_0015, 32'h0, 1);

        // Reset while a data read is outstanding, then a stray ack.
        pc_f = 32'h8; alu_result_m = 32'h44; mem_write_m = 0; dly_a = 0; dly_b = 99;
        exp_q.push_back(mk(1, 0, 0, '0, '0));
        exp_q.push_back(mk(1, 1, 0, 10'd2, '0));
        exp_q.push_back(mk(1, 0, 0, '0, '0));
        exp_q.push_back(mk(1, 1, 0, 10'h11, '0));
        wait_drain();
        reset = 1;
        exp_q.push_back(mk(1, 1, 0, 10'h11, '0));
        e = mk(1, 0, 0, '0, '0);
        e.chk_data = 1; e.inst = NOP; e.rd = 0; e.err = 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 stray_ack = 1;
        @(posedge clk);
        #1 reset = 0;
        m_inst = NOP; m_rd = 0; m_err = 0;
        run_step(32'h3, 32'h43, 0, 0, 0, 0, 1, 32'h0050_0093, 32'hDEAD_BEEF, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
